fatorador_ctrl: RTL and testbench

- Sequencing controller for the prime-factorization datapath.
- Latches a 16-bit value on start, then runs trial division on one shared sequential divider.
- Stores up to NUM_SLOTS distinct prime factors in ascending order, then raises done.
- Sits between the stimulus/switch source and the 7-segment encoding in fatorador_top.

---
 rtl/fatorador_pkg.sv | 18 +
 rtl/fatorador_div.sv | 62 ++++++
 rtl/fatorador_ctrl.sv | 148 ++++++++++++++
 tb/tb_fatorador_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fatorador_pkg.sv
// Shared definitions for the prime-factorization controller: state encoding,
// default sizes and the value stored in an unused result slot.
package fatorador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLOTS = 4;

    localparam logic [DEF_WIDTH-1:0] EMPTY_SLOT = '0;

endpackage

// File: rtl/fatorador_div.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH cycles from
// div_start to a one-cycle div_done. A new div_start restarts it at any time.
module fatorador_div #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             running_q, done_q;
    logic [WIDTH:0]   trial, diff;
    logic             fits;

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        fits  = (trial >= {1'b0, dvs_q});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (div_start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            dvs_q     <= divisor;
            cnt_q     <= CW'(WIDTH);
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else if (running_q) begin
            rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q - CW'(1);
            // The final iteration both ends the run and raises done
            if (cnt_q == CW'(1)) begin
                running_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_done  = done_q;

endmodule

// File: rtl/fatorador_ctrl.sv
// Trial-division factorization controller storing distinct primes in ascending order.
// Build option FATORADOR_CHANGE_DETECT_EN: any change of value restarts the run.
module fatorador_ctrl
    import fatorador_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_SLOTS = DEF_SLOTS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] factor0,
    output logic [WIDTH-1:0] factor1,
    output logic [WIDTH-1:0] factor2,
    output logic [WIDTH-1:0] factor3,
    output logic [2:0]       count,
    output logic             overflow
);
    localparam int DW = WIDTH / 2 + 1;
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [2:0] SLOTS = 3'(NUM_SLOTS);

    state_e           state_q;
    logic [WIDTH-1:0] n_q, last_q;
    logic [DW-1:0]    d_q;
    logic [WIDTH-1:0] factor_q [NUM_SLOTS];
    logic [2:0]       count_q;
    logic             overflow_q, busy_q, done_q;

    logic [2*DW-1:0]  dSq, nWide;
    logic [WIDTH-1:0] dWide, recVal, quotient, remainder;
    logic             nLow, dOver, divStart, divDone, startAcc, abortRun, recEn;

`ifdef FATORADOR_CHANGE_DETECT_EN
    logic [WIDTH-1:0] valuePrev_q;

    always_ff @(posedge clock) begin
        valuePrev_q <= value;
    end

    assign abortRun = (value != valuePrev_q) && !reset;
    assign startAcc = (start && (state_q == ST_IDLE)) || abortRun;
`else
    assign abortRun = 1'b0;
    assign startAcc = start && (state_q == ST_IDLE);
`endif

    // d*d is formed at full double width so the loop bound never wraps
    always_comb begin
        nWide    = {{(2*DW-WIDTH){1'b0}}, n_q};
        dSq      = {{DW{1'b0}}, d_q} * {{DW{1'b0}}, d_q};
        dWide    = {{(WIDTH-DW){1'b0}}, d_q};
        nLow     = (n_q < WIDTH'(2));
        dOver    = (dSq > nWide);
        divStart = (state_q == ST_CHECK) && !nLow && !dOver;
        recEn    = 1'b0;
        recVal   = '0;
        if ((state_q == ST_CHECK) && !nLow && dOver && (n_q != last_q)) begin
            recEn  = 1'b1;
            recVal = n_q;
        end else if ((state_q == ST_UPDATE) && (remainder == '0) && (dWide != last_q)) begin
            recEn  = 1'b1;
            recVal = dWide;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            last_q     <= '0;
            factor_q   <= '{default: WIDTH'(EMPTY_SLOT)};
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (startAcc) begin
            state_q    <= ST_CHECK;
            n_q        <= value;
            d_q        <= DW'(2);
            last_q     <= '0;
            factor_q   <= '{default: WIDTH'(EMPTY_SLOT)};
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Once every slot is taken, further primes only flag overflow
            if (recEn) begin
                if (count_q < SLOTS) begin
                    factor_q[count_q[IW-1:0]] <= recVal;
                    count_q <= count_q + 3'd1;
                end else begin
                    overflow_q <= 1'b1;
                end
                last_q <= recVal;
            end
            unique case (state_q)
                ST_IDLE: ;
                ST_CHECK: begin
                    if (nLow || dOver) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (divDone) state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (remainder == '0) n_q <= quotient;
                    else d_q <= (d_q == DW'(2)) ? DW'(3) : d_q + DW'(2);
                    state_q <= ST_CHECK;
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    fatorador_div #(.WIDTH(WIDTH)) uDiv (
        .clock     (clock),
        .reset     (reset | abortRun),
        .div_start (divStart),
        .dividend  (n_q),
        .divisor   (dWide),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (divDone)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign factor0  = factor_q[0];
    assign factor1  = factor_q[1];
    assign factor2  = factor_q[2];
    assign factor3  = factor_q[3];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fatorador_ctrl.sv
// Directed, table-driven bench for fatorador_ctrl with hand-computed factor lists,
// plus sequences for short-value timing, mid-run reset and value changes.
module tb_fatorador_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;
    logic        busy, done, overflow;
    logic [15:0] factor0, factor1, factor2, factor3;
    logic [2:0]  count;

    int asserts  = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] value;
        logic [15:0] f0, f1, f2, f3;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    localparam int NUM_VECS = 9;
    localparam int DONE_LIMIT = 128 * (16 + 3) + 4;

    vec_t vecs [NUM_VECS];

    fatorador_ctrl #(.WIDTH(16), .NUM_SLOTS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .factor0  (factor0),
        .factor1  (factor1),
        .factor2  (factor2),
        .factor3  (factor3),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives value+start for one clock; returns 1ns after the sampling edge
    task automatic applyStimulus(input logic [15:0] v);
        @(negedge clock);
        value = v;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < limit) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic checkResults(input string tag, input vec_t v);
        checkOutput({tag, " factor0"}, 32'(factor0), 32'(v.f0));
        checkOutput({tag, " factor1"}, 32'(factor1), 32'(v.f1));
        checkOutput({tag, " factor2"}, 32'(factor2), 32'(v.f2));
        checkOutput({tag, " factor3"}, 32'(factor3), 32'(v.f3));
        checkOutput({tag, " count"}, 32'(count), 32'(v.cnt));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
    endtask

    task automatic runVector(input vec_t v);
        int    cycles;
        string tag;
        tag = $sformatf("v%0d", v.value);
        applyStimulus(v.value);
        checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
        waitDone(DONE_LIMIT, cycles);
        checkOutput({tag, " done within limit"}, 32'(done), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        checkResults(tag, v);
        @(posedge clock);
        #1;
        checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
        checkResults({tag, " held"}, v);
    endtask

    initial begin
        int   cycles;
        int   donePulses;
        vec_t v;

        vecs[0] = '{16'd350,   16'd2,     16'd5,  16'd7, 16'd0, 3'd3, 1'b0};
        vecs[1] = '{16'd210,   16'd2,     16'd3,  16'd5, 16'd7, 3'd4, 1'b0};
        vecs[2] = '{16'd85,    16'd5,     16'd17, 16'd0, 16'd0, 3'd2, 1'b0};
        vecs[3] = '{16'd11,    16'd11,    16'd0,  16'd0, 16'd0, 3'd1, 1'b0};
        vecs[4] = '{16'd2310,  16'd2,     16'd3,  16'd5, 16'd7, 3'd4, 1'b1};
        vecs[5] = '{16'd65521, 16'd65521, 16'd0,  16'd0, 16'd0, 3'd1, 1'b0};
        vecs[6] = '{16'd64,    16'd2,     16'd0,  16'd0, 16'd0, 3'd1, 1'b0};
        vecs[7] = '{16'd36,    16'd2,     16'd3,  16'd0, 16'd0, 3'd2, 1'b0};
        vecs[8] = '{16'd30030, 16'd2,     16'd3,  16'd5, 16'd7, 3'd4, 1'b1};

        $display("[TB] reset state");
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0};
        checkResults("reset", v);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < NUM_VECS; i++) runVector(vecs[i]);

        $display("[TB] value 0 and 1 timing");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(16'(k));
            checkOutput($sformatf("v%0d done not early", k), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d busy in check", k), 32'(busy), 32'd1);
            @(posedge clock);
            #1;
            checkOutput($sformatf("v%0d done at 2 cycles", k), 32'(done), 32'd1);
            checkOutput($sformatf("v%0d busy cleared", k), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d count", k), 32'(count), 32'd0);
            checkOutput($sformatf("v%0d factor0", k), 32'(factor0), 32'd0);
            @(posedge clock);
            #1;
        end

        $display("[TB] reset during run");
        applyStimulus(16'd350);
        repeat (25) @(posedge clock);
        #1;
        checkOutput("partial factor0", 32'(factor0), 32'd2);
        checkOutput("partial busy", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0};
        checkResults("midreset", v);
        @(negedge clock);
        reset = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) donePulses++;
        end
        checkOutput("no done after reset", 32'(donePulses), 32'd0);
        runVector('{16'd125, 16'd5, 16'd0, 16'd0, 16'd0, 3'd1, 1'b0});

        $display("[TB] value change during run");
        applyStimulus(16'd350);
        repeat (10) @(posedge clock);
        @(negedge clock);
        value = 16'd85;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(DONE_LIMIT, cycles);
        checkOutput("change done seen", 32'(done), 32'd1);
`ifdef FATORADOR_CHANGE_DETECT_EN
        v = '{16'd85, 16'd5, 16'd17, 16'd0, 16'd0, 3'd2, 1'b0};
`else
        v = '{16'd350, 16'd2, 16'd5, 16'd7, 16'd0, 3'd3, 1'b0};
`endif
        checkResults("change", v);
        donePulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) donePulses++;
        end
        checkOutput("change single done", 32'(donePulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
